// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, control byte, 8/16-bit word address, one data byte, STOP.
// Optional feature macro I2C_STRETCH_EN: honours slave clock stretching on SCL.
module i2c_byte_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         I2C_FREQ   = 250_000,
  parameter bit         ADDR_16    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic        i2c_rh_wl,
  input  logic [15:0] i2c_addr,
  input  logic [7:0]  i2c_data_w,
  output logic [7:0]  i2c_data_r,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        busy,
  inout  wire         scl,
  inout  wire         sda
);

  localparam int DIV   = CLK_FREQ / (I2C_FREQ * 4);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CTRL_W, S_ACK, S_ADDR_H, S_ADDR_L, S_WDATA,
    S_RSTART, S_CTRL_R, S_RDATA, S_MNACK, S_STOP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;      // where to go once the current ACK bit ends
  logic [DIV_W-1:0]   div_cnt_q;
  logic [1:0]         phase_q;
  logic [2:0]         bit_cnt_q;
  logic               rh_wl_q;
  logic [15:0]        addr_q;
  logic [7:0]         data_w_q;
  logic [7:0]         rx_q;
  logic [7:0]         data_r_q;
  logic               ack_q;
  logic               scl_oe_q, scl_oe_d;
  logic               sda_oe_q, sda_oe_d;
  logic [1:0]         sda_sync;
  logic               sda_in;
  logic               hold;
  logic               tick;
  logic               bit_end;
  logic               sample;
  logic               accept;
  logic               is_tx_byte;
  logic               scl_low;
  logic [7:0]         tx_byte;

`ifdef I2C_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scl_sync <= 2'b11;
    else        scl_sync <= {scl_sync[0], scl};
  end

  // SCL was released at phase 1; a slave holding it low freezes the phase sequence.
  assign hold = (phase_q == 2'd1) && !scl_sync[1];
`else
  assign hold = 1'b0;
`endif

  assign sda_in  = sda_sync[1];
  assign busy    = (state_q != S_IDLE);
  assign tick    = busy && (div_cnt_q == DIV_W'(DIV - 1)) && !hold;
  assign bit_end = tick && (phase_q == 2'd3);
  assign sample  = tick && (phase_q == 2'd2);
  assign scl_low = (phase_q == 2'd0) || (phase_q == 2'd3);

  assign is_tx_byte = (state_q == S_CTRL_W) || (state_q == S_ADDR_H) || (state_q == S_ADDR_L) ||
                      (state_q == S_WDATA)  || (state_q == S_CTRL_R);

  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      S_CTRL_W: tx_byte = {SLAVE_ADDR, 1'b0};
      S_CTRL_R: tx_byte = {SLAVE_ADDR, 1'b1};
      S_ADDR_H: tx_byte = addr_q[15:8];
      S_ADDR_L: tx_byte = addr_q[7:0];
      S_WDATA:  tx_byte = data_w_q;
      default:  tx_byte = 8'h00;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i2c_exec) begin
          accept  = 1'b1;
          state_d = S_START;
        end
      end
      S_START, S_RSTART: begin
        // SDA falls during phase 2 while SCL is still high.
        scl_oe_d = (phase_q == 2'd3) || ((state_q == S_RSTART) && (phase_q == 2'd0));
        sda_oe_d = phase_q[1];
        if (bit_end) state_d = (state_q == S_START) ? S_CTRL_W : S_CTRL_R;
      end
      S_CTRL_W, S_ADDR_H, S_ADDR_L, S_WDATA, S_CTRL_R: begin
        scl_oe_d = scl_low;
        sda_oe_d = ~tx_byte[~bit_cnt_q];
        if (bit_end && (bit_cnt_q == 3'd7)) begin
          state_d = S_ACK;
          case (state_q)
            S_CTRL_W: ret_d = ADDR_16 ? S_ADDR_H : S_ADDR_L;
            S_ADDR_H: ret_d = S_ADDR_L;
            S_ADDR_L: ret_d = rh_wl_q ? S_RSTART : S_WDATA;
            S_WDATA:  ret_d = S_STOP;
            default:  ret_d = S_RDATA;
          endcase
        end
      end
      S_ACK: begin
        scl_oe_d = scl_low;
        if (bit_end) state_d = ret_q;
      end
      S_RDATA: begin
        scl_oe_d = scl_low;
        if (bit_end && (bit_cnt_q == 3'd7)) state_d = S_MNACK;
      end
      S_MNACK: begin
        scl_oe_d = scl_low;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // SDA rises during phase 2 while SCL is high.
        scl_oe_d = (phase_q == 2'd0);
        sda_oe_d = !phase_q[1];
        if (bit_end) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      sda_sync <= 2'b11;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      sda_sync <= {sda_sync[0], sda};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      phase_q   <= 2'd0;
      bit_cnt_q <= 3'd0;
    end else if (accept) begin
      div_cnt_q <= '0;
      phase_q   <= 2'd0;
      bit_cnt_q <= 3'd0;
    end else if (busy) begin
      if (div_cnt_q != DIV_W'(DIV - 1)) div_cnt_q <= div_cnt_q + 1'b1;
      else if (!hold)                   div_cnt_q <= '0;
      if (tick) phase_q <= phase_q + 2'd1;
      // 3-bit counter wraps 7->0 at the byte boundary and idles at 0 through ACK bits.
      if (bit_end && (is_tx_byte || (state_q == S_RDATA))) bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rh_wl_q  <= 1'b0;
      addr_q   <= 16'h0000;
      data_w_q <= 8'h00;
      rx_q     <= 8'h00;
      data_r_q <= 8'h00;
      ack_q    <= 1'b0;
    end else if (accept) begin
      rh_wl_q  <= i2c_rh_wl;
      addr_q   <= i2c_addr;
      data_w_q <= i2c_data_w;
      ack_q    <= 1'b0;
    end else begin
      if ((state_q == S_ACK) && sample && sda_in) ack_q <= 1'b1;
      if ((state_q == S_RDATA) && sample) rx_q <= {rx_q[6:0], sda_in};
      if ((state_q == S_RDATA) && bit_end && (bit_cnt_q == 3'd7)) data_r_q <= rx_q;
    end
  end

  assign scl        = scl_oe_q ? 1'b0 : 1'bz;
  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign i2c_done   = (state_q == S_DONE);
  assign i2c_ack    = ack_q;
  assign i2c_data_r = data_r_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: an EEPROM-like bus model decodes START/STOP/bytes and answers;
// expected bus traffic, read data and flags come from a transaction-level reference model.
module tb_i2c_byte_master;

  localparam int CLK_FREQ = 8_000_000;
  localparam int I2C_FREQ = 250_000;
  localparam int DIV      = CLK_FREQ / (I2C_FREQ * 4);
  localparam int BIT_CLKS = 4 * DIV;
  localparam int TIMEOUT  = 60 * BIT_CLKS;
  localparam logic [6:0] SLV = 7'h50;
  localparam int EV_START = 1000;
  localparam int EV_STOP  = 1001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2c_exec = 1'b0;
  logic        i2c_rh_wl = 1'b0;
  logic [15:0] i2c_addr = 16'h0000;
  logic [7:0]  i2c_data_w = 8'h00;
  logic [7:0]  i2c_data_r;
  logic        i2c_done, i2c_ack, busy;
  wire         scl, sda;
  logic        slv_scl_low = 1'b0;
  logic        slv_sda_low = 1'b0;

  pullup (scl);
  pullup (sda);
  assign scl = slv_scl_low ? 1'b0 : 1'bz;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_byte_master #(
    .SLAVE_ADDR (SLV),
    .CLK_FREQ   (CLK_FREQ),
    .I2C_FREQ   (I2C_FREQ),
    .ADDR_16    (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i2c_exec   (i2c_exec),
    .i2c_rh_wl  (i2c_rh_wl),
    .i2c_addr   (i2c_addr),
    .i2c_data_w (i2c_data_w),
    .i2c_data_r (i2c_data_r),
    .i2c_done   (i2c_done),
    .i2c_ack    (i2c_ack),
    .busy       (busy),
    .scl        (scl),
    .sda        (sda)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] default_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Bus model state
  int          bus_log[$];
  int          done_cnt = 0;
  int          clk_cnt = 0;
  int          last_rise = 0;
  int          min_iv, max_iv, max_ack_iv;
  int          bit_n = 0;
  int          byte_idx = 0;
  int          stretch_cnt = 0;
  logic [7:0]  sh = 8'h00;
  logic [7:0]  rd_byte = 8'h00;
  logic [15:0] ptr = 16'h0000;
  bit          reading = 0;
  bit          nack_first = 0;
  bit          ignore_wr = 0;
  bit          stretch_req = 0;
  logic        scl_p = 1'b1;
  logic        sda_p = 1'b1;
  logic [7:0]  slave_mem [int];

  // Reference model state
  logic [7:0]  ref_mem [int];
  logic [7:0]  last_rd = 8'h00;

  task automatic byte_received(input logic [7:0] b, input logic a);
    bus_log.push_back((a ? 256 : 0) + int'(b));
    if (byte_idx == 0) begin
      reading = b[0];
      if (b[0]) rd_byte = slave_mem.exists(int'(ptr)) ? slave_mem[int'(ptr)] : default_byte(ptr);
    end else if (!reading) begin
      if (byte_idx == 1) ptr[15:8] = b;
      else if (byte_idx == 2) ptr[7:0] = b;
      else if (byte_idx == 3 && !ignore_wr) slave_mem[int'(ptr)] = b;
    end
    byte_idx++;
  endtask

  always @(negedge clk) begin
    int iv;
    clk_cnt++;
    if (!rst_n) begin
      bit_n = 0; byte_idx = 0; reading = 0; stretch_cnt = 0;
      slv_sda_low = 1'b0; slv_scl_low = 1'b0;
    end else begin
      if (i2c_done) done_cnt++;
      if (stretch_cnt > 0) begin
        stretch_cnt--;
        if (stretch_cnt == 0) slv_scl_low = 1'b0;
      end
      if (scl && scl_p && sda_p && !sda) begin
        bus_log.push_back(EV_START);
        bit_n = 0; byte_idx = 0; reading = 0;
      end else if (scl && scl_p && !sda_p && sda) begin
        bus_log.push_back(EV_STOP);
        bit_n = 0;
      end else if (scl && !scl_p) begin
        iv = clk_cnt - last_rise;
        if (bit_n >= 1 && bit_n <= 7) begin
          if (iv < min_iv) min_iv = iv;
          if (iv > max_iv) max_iv = iv;
        end
        if (bit_n == 8 && iv > max_ack_iv) max_ack_iv = iv;
        last_rise = clk_cnt;
        bit_n++;
        if (bit_n <= 8) sh = {sh[6:0], sda};
        else begin
          byte_received(sh, sda);
          bit_n = 0;
        end
      end else if (!scl && scl_p) begin
        slv_sda_low = 1'b0;
        if (bit_n == 8 && !(reading && byte_idx == 1)) begin
          if (nack_first && byte_idx == 0) begin
            nack_first = 0;
            ignore_wr  = 1;
          end else slv_sda_low = 1'b1;
          if (stretch_req) begin
            stretch_req = 0;
            slv_scl_low = 1'b1;
            stretch_cnt = 40;
          end
        end else if (reading && byte_idx == 1 && bit_n <= 7) begin
          slv_sda_low = !rd_byte[7 - bit_n];
        end
      end
    end
    scl_p = scl;
    sda_p = sda;
  end

  task automatic run_txn(input bit rw, input logic [15:0] addr, input logic [7:0] data,
                         input bit nack, input bit mid_exec, input bit done_exec, input bit stretch);
    int exp_log[$];
    int d0;
    bit got_done;
    logic [7:0] exp_rd;

    exp_log.push_back(EV_START);
    exp_log.push_back((nack ? 256 : 0) + int'({SLV, 1'b0}));
    exp_log.push_back(int'(addr[15:8]));
    exp_log.push_back(int'(addr[7:0]));
    if (rw) begin
      exp_rd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : default_byte(addr);
      exp_log.push_back(EV_START);
      exp_log.push_back(int'({SLV, 1'b1}));
      exp_log.push_back(256 + int'(exp_rd));
      last_rd = exp_rd;
    end else begin
      exp_log.push_back(int'(data));
      if (!nack) ref_mem[int'(addr)] = data;
    end
    exp_log.push_back(EV_STOP);

    bus_log.delete();
    nack_first = nack; ignore_wr = 0; stretch_req = stretch;
    min_iv = 1 << 30; max_iv = 0; max_ack_iv = 0;
    d0 = done_cnt;

    @(negedge clk);
    i2c_rh_wl = rw; i2c_addr = addr; i2c_data_w = data; i2c_exec = 1'b1;
    @(negedge clk);
    i2c_exec = 1'b0; i2c_rh_wl = !rw; i2c_addr = ~addr; i2c_data_w = ~data;
    check("busy_after_exec", busy, 1);

    if (mid_exec) begin
      repeat ($urandom_range(BIT_CLKS, 20 * BIT_CLKS)) @(negedge clk);
      i2c_exec = 1'b1;
      @(negedge clk);
      i2c_exec = 1'b0;
    end

    got_done = 0;
    for (int w = 0; w < TIMEOUT && !got_done; w++) begin
      @(negedge clk);
      if (i2c_done) got_done = 1;
    end
    check("done_seen", got_done, 1);
    if (got_done) begin
      check("busy_in_done", busy, 1);
      check("ack_flag", i2c_ack, nack);
      check("data_r", i2c_data_r, last_rd);
      if (done_exec) begin
        i2c_rh_wl = 1'b1; i2c_addr = 16'hFFFF; i2c_exec = 1'b1;
      end
      @(negedge clk);
      i2c_exec = 1'b0;
      check("done_width", i2c_done, 0);
      check("busy_after_done", busy, 0);
    end

    repeat (2 * BIT_CLKS) @(negedge clk);
    check("busy_stays_low", busy, 0);
    check("done_count", done_cnt - d0, 1);
    check("ack_held", i2c_ack, nack);
    check("data_r_held", i2c_data_r, last_rd);
    check("log_len", bus_log.size(), exp_log.size());
    foreach (exp_log[i]) if (i < bus_log.size()) check($sformatf("log[%0d]", i), bus_log[i], exp_log[i]);
    check("bit_period_min", min_iv, BIT_CLKS);
    check("bit_period_max", max_iv, BIT_CLKS);
    if (stretch) check("stretch_pause", int'(max_ack_iv > BIT_CLKS), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", i2c_done, 0);
    check("rst_ack", i2c_ack, 0);
    check("rst_data_r", i2c_data_r, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_txn(1'b0, 16'h0012, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 16'h0012, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0100, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0040, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);

    // Abort inside ADDR_L after a transaction that left ack=1 and data_r nonzero.
    run_txn(1'b1, 16'h0007, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    i2c_rh_wl = 1'b0; i2c_addr = 16'h0034; i2c_data_w = 8'hC3; i2c_exec = 1'b1;
    @(negedge clk);
    i2c_exec = 1'b0;
    repeat (22 * BIT_CLKS + BIT_CLKS / 2 - 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sda, 1);
    check("abort_busy", busy, 0);
    check("abort_done", i2c_done, 0);
    check("abort_ack", i2c_ack, 0);
    check("abort_data_r", i2c_data_r, 0);
    last_rd = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(1'b1, 16'h0040, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef I2C_STRETCH_EN
    run_txn(1'b0, 16'h0055, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn(1'b1, 16'h0055, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 10; k++) begin
      logic [15:0] a;
      a = {7'h00, 1'($urandom_range(0, 1)), 5'h00, 3'($urandom_range(0, 7))};
      run_txn(1'($urandom_range(0, 1)), a, 8'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
